// File: rtl/cute_lock_pkg.sv
// cute_lock_pkg: shared state encoding, default key geometry and the wrap counter width
package cute_lock_pkg;
  typedef enum logic [1:0] {EMPTY, LOAD, ARMED, RUN} state_t;
  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_KEY_W = 2;
  localparam int WRAP_CNT_W = 8;
endpackage

// File: rtl/cute_key_slot_rf.sv
// cute_key_slot_rf: NUM_SLOTS x KEY_W key word registers, one write port, one async read port, async clear
module cute_key_slot_rf #(
  parameter int NUM_SLOTS = 4,
  parameter int KEY_W = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         we,
  input  logic [$clog2(NUM_SLOTS)-1:0] waddr,
  input  logic [KEY_W-1:0]             wdata,
  input  logic [$clog2(NUM_SLOTS)-1:0] raddr,
  output logic [KEY_W-1:0]             rdata
);
  logic [KEY_W-1:0] mem [NUM_SLOTS];
  always_ff @(posedge clock or posedge reset)
    if (reset) for (int i = 0; i < NUM_SLOTS; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/cute_key_scheduler.sv
// cute_key_scheduler: loads key words then sequences them to the locked FSM; KEY_SCHED_WRAPCNT_EN adds wrap_count
module cute_key_scheduler
  import cute_lock_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int KEY_W = DEF_KEY_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cfg_valid,
  input  logic [KEY_W-1:0]             cfg_data,
  output logic                         cfg_ready,
  input  logic                         run,
  input  logic                         hold,
  input  logic                         flush,
  output logic [KEY_W-1:0]             key_out,
  output logic                         key_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] slot,
  output logic                         wrap_pulse,
`ifdef KEY_SCHED_WRAPCNT_EN
  output logic [WRAP_CNT_W-1:0]        wrap_count,
`endif
  output logic                         busy
);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam logic [SW-1:0] LAST = SW'(NUM_SLOTS - 1);
  state_t state, ns;
  logic [SW-1:0] wr_ptr, nslot;
  logic [KEY_W-1:0] rd;
  logic xfer, step, wrap;
  cute_key_slot_rf #(.NUM_SLOTS(NUM_SLOTS), .KEY_W(KEY_W)) u_rf (
    .clock(clock),
    .reset(reset),
    .we(xfer),
    .waddr(wr_ptr),
    .wdata(cfg_data),
    .raddr(nslot),
    .rdata(rd)
  );
  always_comb begin
    xfer = cfg_valid & cfg_ready & ~flush;
    step = (state == RUN) & run & ~hold & ~flush;
    wrap = step & (slot == LAST);
    ns = flush ? EMPTY :
         state == EMPTY ? (xfer ? LOAD : EMPTY) :
         state == LOAD ? ((xfer && wr_ptr == LAST) ? ARMED : LOAD) :
         run ? RUN : ARMED;
    nslot = (ns != RUN) ? '0 : step ? slot + 1'b1 : (state == RUN) ? slot : '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= EMPTY;
      wr_ptr <= '0;
      slot <= '0;
      key_out <= '0;
      key_valid <= 1'b0;
      wrap_pulse <= 1'b0;
      busy <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state <= ns;
      wr_ptr <= flush ? '0 : xfer ? wr_ptr + 1'b1 : wr_ptr;
      slot <= nslot;
      key_out <= (ns == RUN) ? rd : '0;
      key_valid <= ns == RUN;
      wrap_pulse <= wrap;
      busy <= ns == LOAD || ns == RUN;
      cfg_ready <= ns == EMPTY || ns == LOAD;
    end
`ifdef KEY_SCHED_WRAPCNT_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) wrap_count <= '0;
    else if (flush) wrap_count <= '0;
    else if (wrap && wrap_count != '1) wrap_count <= wrap_count + 1'b1;
`endif
endmodule

// File: tb/tb_cute_key_scheduler.sv
// tb_cute_key_scheduler: directed self-checking bench for cute_key_scheduler
module tb_cute_key_scheduler;
  logic clock = 1'b0, reset = 1'b1;
  logic cfg_valid = 1'b0, run = 1'b0, hold = 1'b0, flush = 1'b0;
  logic [1:0] cfg_data = '0, key_out, slot;
  logic cfg_ready, key_valid, wrap_pulse, busy;
`ifdef KEY_SCHED_WRAPCNT_EN
  logic [7:0] wrap_count;
`endif
  int tests = 0, fails = 0;
  cute_key_scheduler dut (
    .clock(clock),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .run(run),
    .hold(hold),
    .flush(flush),
    .key_out(key_out),
    .key_valid(key_valid),
    .slot(slot),
    .wrap_pulse(wrap_pulse),
`ifdef KEY_SCHED_WRAPCNT_EN
    .wrap_count(wrap_count),
`endif
    .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic load(input logic [1:0] w0, w1, w2, w3);
    logic [1:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1;
      cfg_data = w[i];
      tick();
    end
    cfg_valid = 1'b0;
  endtask
  task automatic test_reset();
    #2;
    tests++;
    if ({key_valid, slot, key_out, wrap_pulse, busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b exp=%b", {key_valid, slot, key_out, wrap_pulse, busy}, 7'b0);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
    tests++;
    if ({cfg_ready, busy} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release {cfg_ready,busy} got=%b exp=10", {cfg_ready, busy});
    end
  endtask
  task automatic test_load();
    cfg_valid = 1'b1;
    cfg_data = 2'd1;
    tick();
    tests++;
    if ({cfg_ready, busy, key_valid} !== 3'b110) begin
      fails++;
      $display("FAIL load_first {cfg_ready,busy,key_valid} got=%b exp=110", {cfg_ready, busy, key_valid});
    end
    cfg_data = 2'd2;
    tick();
    cfg_data = 2'd3;
    tick();
    cfg_data = 2'd0;
    tick();
    cfg_valid = 1'b0;
    tests++;
    if ({cfg_ready, busy, key_valid} !== 3'b000) begin
      fails++;
      $display("FAIL load_armed {cfg_ready,busy,key_valid} got=%b exp=000", {cfg_ready, busy, key_valid});
    end
  endtask
  task automatic test_run();
    logic [5:0] exp [5];
    exp = '{6'b1_00_01_0, 6'b1_01_10_0, 6'b1_10_11_0, 6'b1_11_00_0, 6'b1_00_01_1};
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if ({key_valid, slot, key_out, wrap_pulse} !== exp[i]) begin
        fails++;
        $display("FAIL run_seq[%0d] {kv,slot,key,wrap} got=%b exp=%b", i, {key_valid, slot, key_out, wrap_pulse}, exp[i]);
      end
    end
    run = 1'b0;
    tick();
    tests++;
    if ({key_valid, slot, key_out, wrap_pulse, busy} !== 7'b0) begin
      fails++;
      $display("FAIL run_stop got=%b exp=%b", {key_valid, slot, key_out, wrap_pulse, busy}, 7'b0);
    end
  endtask
  task automatic test_hold();
    run = 1'b1;
    repeat (3) tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({key_valid, slot, key_out, wrap_pulse} !== 6'b1_10_11_0) begin
        fails++;
        $display("FAIL hold[%0d] got=%b exp=%b", i, {key_valid, slot, key_out, wrap_pulse}, 6'b1_10_11_0);
      end
    end
    hold = 1'b0;
    tick();
    tests++;
    if ({key_valid, slot, key_out, wrap_pulse} !== 6'b1_11_00_0) begin
      fails++;
      $display("FAIL hold_resume got=%b exp=%b", {key_valid, slot, key_out, wrap_pulse}, 6'b1_11_00_0);
    end
    tick();
    tests++;
    if ({key_valid, slot, key_out, wrap_pulse} !== 6'b1_00_01_1) begin
      fails++;
      $display("FAIL hold_wrap got=%b exp=%b", {key_valid, slot, key_out, wrap_pulse}, 6'b1_00_01_1);
    end
    run = 1'b0;
    tick();
  endtask
  task automatic test_run_deassert();
    cfg_valid = 1'b1;
    cfg_data = 2'd2;
    tick();
    cfg_valid = 1'b0;
    tests++;
    if ({cfg_ready, busy} !== 2'b00) begin
      fails++;
      $display("FAIL cfg_ignored {cfg_ready,busy} got=%b exp=00", {cfg_ready, busy});
    end
    run = 1'b1;
    tick();
    tick();
    tests++;
    if ({key_valid, slot, key_out} !== 5'b1_01_10) begin
      fails++;
      $display("FAIL deassert_pre got=%b exp=%b", {key_valid, slot, key_out}, 5'b1_01_10);
    end
    run = 1'b0;
    tick();
    tests++;
    if ({key_valid, slot, key_out, busy, cfg_ready} !== 7'b0) begin
      fails++;
      $display("FAIL deassert_armed got=%b exp=%b", {key_valid, slot, key_out, busy, cfg_ready}, 7'b0);
    end
    run = 1'b1;
    tick();
    tests++;
    if ({key_valid, slot, key_out} !== 5'b1_00_01) begin
      fails++;
      $display("FAIL reassert got=%b exp=%b", {key_valid, slot, key_out}, 5'b1_00_01);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run = 1'b0;
    tests++;
    if ({key_valid, key_out, busy, cfg_ready} !== 5'b0_00_01) begin
      fails++;
      $display("FAIL flush_run got=%b exp=%b", {key_valid, key_out, busy, cfg_ready}, 5'b0_00_01);
    end
  endtask
  task automatic test_flush();
    logic [1:0] exp [4];
    exp = '{2'd2, 2'd1, 2'd0, 2'd3};
    cfg_valid = 1'b1;
    cfg_data = 2'd3;
    tick();
    tick();
    flush = 1'b1;
    cfg_data = 2'd1;
    tick();
    flush = 1'b0;
    cfg_valid = 1'b0;
    tests++;
    if ({cfg_ready, busy} !== 2'b10) begin
      fails++;
      $display("FAIL flush_load {cfg_ready,busy} got=%b exp=10", {cfg_ready, busy});
    end
    load(2'd2, 2'd1, 2'd0, 2'd3);
    tests++;
    if ({cfg_ready, busy} !== 2'b00) begin
      fails++;
      $display("FAIL reload_armed {cfg_ready,busy} got=%b exp=00", {cfg_ready, busy});
    end
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({slot, key_out} !== {2'(i), exp[i]}) begin
        fails++;
        $display("FAIL reload_seq[%0d] {slot,key} got=%b exp=%b", i, {slot, key_out}, {2'(i), exp[i]});
      end
    end
    run = 1'b0;
    tick();
  endtask
  task automatic test_reset_mid_run();
    run = 1'b1;
    repeat (4) tick();
    tests++;
    if ({key_valid, slot} !== 3'b1_11) begin
      fails++;
      $display("FAIL pre_reset {kv,slot} got=%b exp=111", {key_valid, slot});
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({key_valid, slot, key_out, wrap_pulse, busy} !== 7'b0) begin
      fails++;
      $display("FAIL async_reset got=%b exp=%b", {key_valid, slot, key_out, wrap_pulse, busy}, 7'b0);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    tests++;
    if ({cfg_ready, busy, key_valid} !== 3'b100) begin
      fails++;
      $display("FAIL post_reset_empty {cfg_ready,busy,kv} got=%b exp=100", {cfg_ready, busy, key_valid});
    end
    run = 1'b0;
  endtask
`ifdef KEY_SCHED_WRAPCNT_EN
  task automatic test_wrap_count();
    load(2'd1, 2'd2, 2'd3, 2'd0);
    run = 1'b1;
    repeat (9) tick();
    tests++;
    if (wrap_count !== 8'd2) begin
      fails++;
      $display("FAIL wrap_count_2 got=%0d exp=2", wrap_count);
    end
    repeat (1210) tick();
    tests++;
    if (wrap_count !== 8'd255) begin
      fails++;
      $display("FAIL wrap_count_sat got=%0d exp=255", wrap_count);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run = 1'b0;
    tests++;
    if (wrap_count !== 8'd0) begin
      fails++;
      $display("FAIL wrap_count_flush got=%0d exp=0", wrap_count);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_load();
    test_run();
    test_hold();
    test_run_deassert();
    test_flush();
    test_reset_mid_run();
`ifdef KEY_SCHED_WRAPCNT_EN
    test_wrap_count();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
